// File: rtl/mulacc_pkg.sv
// Shared definitions for the mulacc sequencer: FSM state encoding and default datapath width.
package mulacc_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/mulacc_seq_if.sv
// Operand stream and result port of the mulacc sequencer.
// valid/ready: a beat transfers on a rising clk edge where valid and ready are both high;
// once valid is raised the sender holds valid and payload stable until that transfer.
interface mulacc_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic [CNT_W-1:0] res_count;

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_data, res_ovf, res_count
    );

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_ovf, res_count
    );
endinterface

// File: rtl/mulacc_seq_fifo.sv
// Operand FIFO with a registered ready flag; a push while full is refused even if a pop occurs.
module mulacc_seq_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         ready,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    assign empty      = (count == '0);
    assign push_ok    = push & ready;
    assign pop_ok     = pop & ~empty;
    assign count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= (count_next != FULL_CNT);
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mulacc_seq.sv
// Sequencer feeding a mulacc stage one operand per cycle and returning one result beat per packet.
module mulacc_seq
    import mulacc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    mulacc_seq_if.slave      bus,
    output logic             mac_clear,
    output logic             mac_en,
    output logic [WIDTH-1:0] mac_x,
    input  logic [WIDTH-1:0] mac_out,
    input  logic             mac_ovf,
    output state_t           dbg_state
);
    state_t           state, state_next;
    logic [WIDTH:0]   head;
    logic             empty;
    logic             head_last;
    logic [CNT_W-1:0] cnt;
    logic             res_valid_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign head_last     = head[WIDTH];
    assign dbg_state     = state;
    assign bus.res_valid = res_valid_q;

    mulacc_seq_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.in_valid),
        .din     ({bus.in_last, bus.in_data}),
        .pop     (mac_en),
        .ready   (bus.in_ready),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RUN: if (!empty) state_next = head_last ? S_CAPTURE : S_RUN;
            S_CAPTURE:     state_next = S_HOLD;
            S_HOLD:        if (res_valid_q && bus.res_ready) state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    // mulacc is held in clear while we are in reset so it starts from a known product.
    always_comb begin
        mac_en    = 1'b0;
        mac_clear = ~reset_n;
        case (state)
            S_IDLE: if (!empty) begin
                mac_en    = 1'b1;
                mac_clear = 1'b1;
            end
            S_RUN:   if (!empty) mac_en = 1'b1;
            default: ;
        endcase
        mac_x = mac_en ? head[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            res_valid_q   <= 1'b0;
            bus.res_data  <= '0;
            bus.res_ovf   <= 1'b0;
            bus.res_count <= '0;
        end else begin
            if (mac_en) cnt <= (state == S_IDLE) ? CNT_W'(1) : sat_inc(cnt);
            if (state == S_CAPTURE) begin
                res_valid_q   <= 1'b1;
                bus.res_data  <= mac_out;
                bus.res_ovf   <= mac_ovf;
                bus.res_count <= cnt;
            end else if (state == S_HOLD && res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mulacc_seq.sv
// Directed bench for mulacc_seq with a behavioural mulacc stage alongside it.
module tb_mulacc_seq;
    import mulacc_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         mac_clear;
    logic         mac_en;
    logic [W-1:0] mac_x;
    logic [W-1:0] mac_out;
    logic         mac_ovf;
    state_t       dbg_state;

    mulacc_seq_if #(.WIDTH(W), .CNT_W(16)) bus ();

    mulacc_seq #(.WIDTH(W), .DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .mac_clear (mac_clear),
        .mac_en    (mac_en),
        .mac_x     (mac_x),
        .mac_out   (mac_out),
        .mac_ovf   (mac_ovf),
        .dbg_state (dbg_state)
    );

    // mulacc: synchronous clear; en multiplies the running product (1 when cleared) by x.
    logic [2*W-1:0] prod;
    initial begin
        mac_out = '0;
        mac_ovf = 1'b0;
    end
    always @(posedge clk) begin
        if (mac_en) begin
            prod = (mac_clear ? 64'd1 : {32'd0, mac_out}) * {32'd0, mac_x};
            mac_out <= prod[W-1:0];
            mac_ovf <= (mac_clear ? 1'b0 : mac_ovf) | (|prod[2*W-1:W]);
        end else if (mac_clear) begin
            mac_out <= 32'd1;
            mac_ovf <= 1'b0;
        end
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int push_cnt = 0;
    int beat_cnt = 0;
    logic clr_en_seen = 1'b0;

    logic [W-1:0] exp_q[$];
    logic         exp_ovf_q[$];
    logic [15:0]  exp_cnt_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_res(input logic [W-1:0] d, input logic o, input logic [15:0] c);
        exp_q.push_back(d);
        exp_ovf_q.push_back(o);
        exp_cnt_q.push_back(c);
    endtask

    // driver: called at a negedge, returns at the negedge after the beat transferred
    task automatic send(input logic [W-1:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // scoreboard: inputs change on negedges, so values seen 2ns later hold through the next posedge
    always begin
        @(negedge clk);
        #2;
        if (reset_n && mac_clear && mac_en) clr_en_seen = 1'b1;
        if (bus.in_valid && bus.in_ready) push_cnt++;
        if (bus.res_valid && bus.res_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", bus.res_data, 32'hdead_beef);
            end else begin
                check("res_data",  bus.res_data,           exp_q.pop_front());
                check("res_ovf",   32'(bus.res_ovf),       32'(exp_ovf_q.pop_front()));
                check("res_count", 32'(bus.res_count),     32'(exp_cnt_q.pop_front()));
            end
        end
    end

    int base;

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_mac_clear", 32'(mac_clear),     32'd1);
        check("rst_mac_en",    32'(mac_en),        32'd0);
        check("rst_mac_x",     mac_x,              32'd0);
        check("rst_res_data",  bus.res_data,       32'd0);
        check("rst_res_count", 32'(bus.res_count), 32'd0);
        check("rst_state",     32'(dbg_state),     32'(S_IDLE));
        reset_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);

        // 1: three-operand packet
        expect_res(32'd105, 1'b0, 16'd3);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b1);
        wait_drain();

        // 2: single-operand packet loads and clears in one cycle
        clr_en_seen = 1'b0;
        expect_res(32'd9, 1'b0, 16'd1);
        send(32'd9, 1'b1);
        wait_drain();
        check("clear_with_en", 32'(clr_en_seen), 32'd1);

        // 3: overflow is sticky within a packet and cleared by the next
        expect_res(32'd0, 1'b1, 16'd2);
        send(32'h0001_0000, 1'b0);
        send(32'h0001_0000, 1'b1);
        expect_res(32'd2, 1'b0, 16'd1);
        send(32'd2, 1'b1);
        wait_drain();

        // 4: result backpressure fills the FIFO behind a held result
        bus.res_ready = 1'b0;
        expect_res(32'd6, 1'b0, 16'd2);
        expect_res(32'd12, 1'b0, 16'd6);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        base = push_cnt;
        fork
            begin
                send(32'd1, 1'b0);
                send(32'd2, 1'b0);
                send(32'd3, 1'b0);
                send(32'd1, 1'b0);
                send(32'd2, 1'b0);
                send(32'd1, 1'b1);
            end
        join_none
        repeat (3) @(negedge clk);
        check("hold_res_valid", 32'(bus.res_valid), 32'd1);
        check("hold_data_early", bus.res_data, 32'd6);
        repeat (9) @(negedge clk);
        check("hold_in_ready",    32'(bus.in_ready),    32'd0);
        check("hold_buffered",    32'(push_cnt - base), 32'd4);
        check("hold_res_data",    bus.res_data,         32'd6);
        check("hold_res_count",   32'(bus.res_count),   32'd2);
        bus.res_ready = 1'b1;
        wait fork;
        wait_drain();

        // 5: gaps in the operand stream stall the multiplier
        expect_res(32'd64, 1'b0, 16'd3);
        send(32'd4, 1'b0);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            check("gap_mac_en_a", 32'(mac_en), 32'd0);
        end
        send(32'd4, 1'b0);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            check("gap_mac_en_b", 32'(mac_en), 32'd0);
        end
        send(32'd4, 1'b1);
        wait_drain();

        // 6: reset mid-packet drops the partial packet
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst_mac_en",    32'(mac_en),        32'd0);
        check("midrst_state",     32'(dbg_state),     32'(S_IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_res(32'd6, 1'b0, 16'd2);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        wait_drain();
        repeat (5) @(negedge clk);
        check("total_beats", 32'(beat_cnt), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
